fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the PC register/instruction memory and the decode stage. Each cycle it captures the current PC and the instruction word read at that PC. It buffers up to DEPTH fetched pairs and presents them in order to decode through a valid/ready handshake. It back-pressures the PC register when full and discards all buffered fetches on a control-flow redirect.

## Interface
- DEPTH, 4, number of buffered fetch entries; power of two, ≥2
- clock  in  1  rising-edge clock for all state
- reset_n  in  1  asynchronous, active-low reset
- pc_in  in  32  address of the instruction being fetched this cycle (PC register output)
- instr_in  in  32  instruction memory read data for pc_in, valid in the same cycle
- fetch_valid  in  1  pc_in/instr_in hold a real fetch this cycle
- fetch_ready  out  1  queue can accept; PC register advances only when fetch_valid && fetch_ready
- flush  in  1  redirect (branch/jump taken); discard all entries
- id_valid  out  1  head entry present for decode
- id_pc  out  32  PC of head entry
- id_pc_plus4  out  32  id_pc + 4 (mod 2^32)
- id_instr  out  32  instruction of head entry
- id_ready  in  1  decode consumes head this cycle
- count  out  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}, circular, with head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
- enq = fetch_valid && fetch_ready && !flush. The entry is written at tail, and tail advances by 1.
- deq = id_valid && id_ready && !flush. Head advances by 1.
- count_next = count + enq - deq. Simultaneous enq and deq leave count unchanged.
- fetch_ready = (count != DEPTH). It is combinational from count only, with no dependence on id_ready and no pass-through when full.
- id_valid = (count != 0). id_pc and id_instr are driven from the head entry.
- id_pc_plus4 uses 32-bit wrapping addition, so 0xFFFFFFFC yields 0x00000000.
- When id_valid = 0, id_pc, id_pc_plus4 and id_instr are don't-care. The bench must not check them.
- flush has priority over everything:
  - head, tail and count clear to 0 at the next edge.
  - A same-cycle enqueue is dropped.
  - A same-cycle dequeue does not count as consumed.
- fetch_valid with fetch_ready = 0 is a held fetch. The upstream stage must keep pc_in stable, and no entry is written.

## Timing
- Reset (reset_n = 0, asynchronous): head = tail = 0, count = 0. This gives id_valid = 0 and fetch_ready = 1 while reset is asserted.
- Storage contents are not reset.
- Latency: a pair enqueued at edge N into an empty queue gives id_valid = 1 with that pair after edge N. That is one cycle minimum from fetch to decode, with no combinational fetch-to-decode path.
- Throughput: one enqueue and one dequeue per cycle sustained.
- Full (count = DEPTH): fetch_ready = 0. A dequeue at edge N makes fetch_ready = 1 after edge N.
- Empty (count = 0): id_valid = 0, and id_ready is ignored.
- Flush: id_valid = 0 and fetch_ready = 1 in the cycle after the flush edge. The redirected PC may enqueue in that cycle.
- Reset asserted mid-operation clears all state immediately. Entries present at the time are lost.

## Structure
- Shared package mips_pkg holds:
  - WORD_W = 32
  - RESET_PC = 32'd100, which matches the PC register reset/initial value
  - INSTR_NOP = 32'h00000000
  - the fetch-entry typedef {pc, instr}
- One sub-module is natural: fq_storage, a DEPTH×64 register array with one write port and one asynchronous read port.
- Pointer and count control stays in fetch_queue.

## Test plan
- Reset, then fetch 100/0x20080005 at one edge → id_valid = 1 next cycle, id_pc = 100, id_pc_plus4 = 104, id_instr = 0x20080005, count = 1.
- id_ready = 0 with fetches 100, 104, 108, 112 → count = 4 and fetch_ready = 0. A further fetch 116 is held and not written. After one dequeue, fetch_ready = 1.
- Continuous fetch of 100..140 with id_ready = 1 → count stays 1 and id_pc steps +4 every cycle in order across pointer wrap.
- With 3 entries queued, assert flush together with fetch_valid(pc 200) and id_ready → next cycle count = 0 and id_valid = 0. Fetch of 300 then appears as id_pc = 300 one cycle later.
- Fetch pc = 0xFFFFFFFC → id_pc_plus4 = 0x00000000.
- Pull reset_n low mid-cycle with count = 2 → id_valid = 0, count = 0 and fetch_ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: word width, reset PC, NOP encoding and
// the fetch-entry record buffered between fetch and decode.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC  = 32'd100;
    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Sequential-successor address; wraps modulo 2^32.
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(4);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset.
module fq_storage
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  fetch_entry_t  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output fetch_entry_t  o_rd_data
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the PC/instruction memory and
// decode, with full back-pressure and a flush that discards all entries.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WORD_W-1:0]        pc_in,
    input  logic [WORD_W-1:0]        instr_in,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [WORD_W-1:0]        id_pc,
    output logic [WORD_W-1:0]        id_pc_plus4,
    output logic [WORD_W-1:0]        id_instr,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_enq;
    logic          w_deq;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head_entry;

    // Flush masks both handshakes so a redirect never commits a stale entry.
    assign fetch_ready = (r_count != CW'(DEPTH));
    assign id_valid    = (r_count != '0);
    assign w_enq       = fetch_valid && fetch_ready && !flush;
    assign w_deq       = id_valid && id_ready && !flush;

    assign w_wr_entry.pc    = pc_in;
    assign w_wr_entry.instr = instr_in;

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .i_clock   (clock),
        .i_wr_en   (w_enq),
        .i_wr_addr (r_tail),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_head),
        .o_rd_data (w_head_entry)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty queue presents a NOP bubble so stale storage never looks like code.
    assign id_pc       = w_head_entry.pc;
    assign id_pc_plus4 = pc_plus4(w_head_entry.pc);
    assign id_instr    = id_valid ? w_head_entry.instr : INSTR_NOP;
    assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a driver pushes expected fetch pairs into a
// scoreboard and a negedge monitor pops and compares them on every dequeue.
module tb_fetch_queue;
    import mips_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    fetch_entry_t sb[$];

    fetch_queue #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_ready    (id_ready),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one cycle of stimulus starting just after a rising edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        logic e;
        logic d;
        fetch_entry_t ent;
        fetch_valid = fv;
        pc_in       = pc;
        instr_in    = ins;
        id_ready    = rdy;
        flush       = fl;
        e = fv && (mcount != 4) && !fl;
        d = (mcount != 0) && rdy && !fl;
        if (fl) sb.delete();
        if (e) begin
            ent.pc    = pc;
            ent.instr = ins;
            sb.push_back(ent);
        end
        @(posedge clock);
        #1;
        if (fl) mcount = 0;
        else    mcount = mcount + int'(e) - int'(d);
        fetch_valid = 1'b0;
        id_ready    = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    // Monitor: inputs and outputs are stable between the falling and rising edge.
    always @(negedge clock) begin
        if (reset_n && id_valid && id_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got dequeue of pc %h expected none", id_pc);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                chk("deq_pc", id_pc, e.pc);
                chk("deq_pc_plus4", id_pc_plus4, e.pc + 32'd4);
                chk("deq_instr", id_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        fetch_valid = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        pc_in = 32'h0;
        instr_in = 32'h0;
        #2;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single fetch: visible one cycle later.
        step(1'b1, RESET_PC, 32'h2008_0005, 1'b0, 1'b0);
        chk("lat_id_valid", 32'(id_valid), 32'd1);
        chk("lat_id_pc", id_pc, 32'd100);
        chk("lat_pc_plus4", id_pc_plus4, 32'd104);
        chk("lat_instr", id_instr, 32'h2008_0005);
        chk("lat_count", 32'(count), 32'd1);
        drain();

        // Fill to full, hold a fetch, then free one slot.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'd100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        step(1'b1, 32'd116, 32'hA000_0004, 1'b0, 1'b0);
        chk("held_count", 32'(count), 32'd4);
        step(1'b1, 32'd116, 32'hA000_0004, 1'b1, 1'b0);
        chk("after_deq_count", 32'(count), 32'd3);
        chk("after_deq_fetch_ready", 32'(fetch_ready), 32'd1);
        step(1'b1, 32'd116, 32'hA000_0004, 1'b1, 1'b0);
        chk("held_enq_count", 32'(count), 32'd3);
        drain();

        // Streaming with concurrent enqueue/dequeue across pointer wrap.
        step(1'b1, 32'd100, 32'hB000_0000, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 32'd100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_id_pc", id_pc, 32'd100 + 32'(4 * i));
        end
        drain();

        // Flush with concurrent fetch and dequeue; redirected fetch follows.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'd400 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd3);
        step(1'b1, 32'd200, 32'hC000_00FF, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        chk("flush_fetch_ready", 32'(fetch_ready), 32'd1);
        step(1'b1, 32'd300, 32'hC000_0300, 1'b0, 1'b0);
        chk("redirect_id_valid", 32'(id_valid), 32'd1);
        chk("redirect_id_pc", id_pc, 32'd300);
        drain();

        // PC+4 wraps at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 32'hD000_0001, 1'b0, 1'b0);
        chk("wrap_pc_plus4", id_pc_plus4, 32'h0000_0000);
        drain();

        // Asynchronous reset mid-cycle with two entries queued.
        step(1'b1, 32'd600, 32'hE000_0000, 1'b0, 1'b0);
        step(1'b1, 32'd604, 32'hE000_0001, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_id_valid", 32'(id_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_fetch_ready", 32'(fetch_ready), 32'd1);
        sb.delete();
        mcount = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1'b1, 32'd700, 32'hF000_0000, 1'b0, 1'b0);
        chk("post_rst_id_pc", id_pc, 32'd700);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
